register_bus_sequencer: RTL and testbench
=========================================

// Module: register_bus_sequencer
// PURPOSE
//   Initiator for the register_file rd0/rd1/wr register buses. Accepts one register-move command
//   at a time over a valid/ready handshake and runs it as a multi-cycle sequence of bus reads
//   and writes: MOV, SWAP, CLEAR (all registers) and LOADI (immediate).
//   Sits between the control unit and register_file.
// PARAMETERS
//   ADDR_BITS  3  register address width; the file holds 2**ADDR_BITS registers
//   DATA_BITS  8  register data width
// PORTS
//   clk        in   1          clock, rising edge
//   reset      in   1          asynchronous, active-low reset
//   cmd_valid  in   1          command present
//   cmd_ready  out  1          sequencer can accept a command
//   cmd_op     in   2          00 MOV, 01 SWAP, 10 CLEAR, 11 LOADI
//   cmd_a      in   ADDR_BITS  MOV/LOADI destination; SWAP first register
//   cmd_b      in   ADDR_BITS  MOV source; SWAP second register
//   cmd_imm    in   DATA_BITS  LOADI value
//   done       out  1          one-cycle pulse: command completed
//   rd0_addr   out  ADDR_BITS  rd0_bus.addr
//   rd0_en     out  1          rd0_bus.enable
//   rd0_data   in   DATA_BITS  rd0_bus.data (combinational read, same cycle)
//   rd1_addr   out  ADDR_BITS  rd1_bus.addr
//   rd1_en     out  1          rd1_bus.enable
//   rd1_data   in   DATA_BITS  rd1_bus.data (combinational read, same cycle)
//   wr_addr    out  ADDR_BITS  wr_bus.addr
//   wr_en      out  1          wr_bus.enable (register loads at the rising edge)
//   wr_data    out  DATA_BITS  wr_bus.data
// BEHAVIOUR
//   Reset (reset=0, async): state IDLE; cmd_ready=1; done=0; all enables/addrs/data/temps/counter 0.
//   Accept: edge with cmd_valid && cmd_ready. Capture op/a/b/imm into registers; inputs are don't-care
//     after acceptance. cmd_ready = (state==IDLE). Acceptance never happens outside IDLE.
//   FSM (one state per cycle after acceptance):
//     IDLE    -> MOV | SWAP_RD | CLR | LDI on accept, else IDLE
//     MOV     rd0_en=1, rd0_addr=b; wr_en=1, wr_addr=a, wr_data=rd0_data -> IDLE
//     LDI     wr_en=1, wr_addr=a, wr_data=imm -> IDLE
//     SWAP_RD rd0_en=1 addr a, rd1_en=1 addr b; tmp_a<=rd0_data, tmp_b<=rd1_data -> SWAP_WA
//     SWAP_WA wr_en=1, wr_addr=a, wr_data=tmp_b -> SWAP_WB
//     SWAP_WB wr_en=1, wr_addr=b, wr_data=tmp_a -> IDLE
//     CLR     wr_en=1, wr_addr=cnt, wr_data=0; cnt++; at cnt==2**ADDR_BITS-1 -> IDLE, cnt<=0
//   Enables are 0, and addr/wr_data are 0, in any state where the table above leaves them unstated.
//     No bus output depends combinationally on cmd_* inputs.
//   Latency (accept edge to done high): MOV/LDI 1 cycle, SWAP 3 cycles, CLR 2**ADDR_BITS cycles.
//   done: registered; high for exactly one cycle, the first IDLE cycle after the last write.
//     cmd_ready is also 1 in that cycle, so back-to-back commands run with no bubble.
//   At most one write per cycle; rd0 and rd1 are both active only in SWAP_RD.
//   Edge cases:
//     SWAP a==b: full 3 cycles, register value unchanged.
//     MOV a==b: 1 cycle, value unchanged.
//     CLR counter wraps to 0 internally and never exceeds 2**ADDR_BITS-1.
//     Reset mid-command: abort immediately to IDLE, no done. Writes already made stay; no
//       further writes.
//     cmd_valid held high continuously: a new command is taken each time the FSM is in IDLE.
// TESTING
//   1 Reset: hold reset=0 with cmd_valid=1 -> no enables, done=0, cmd_ready=1; release -> accept next edge.
//   2 LOADI a=3 imm=8'hA5, then MOV a=5 b=3 back-to-back -> r3=A5 after 1 cycle, r5=A5 next; 2 done pulses.
//   3 r1=11, r6=66; SWAP a=1 b=6 -> SWAP_RD reads both, r1=66 then r6=11 on next 2 edges; done at cycle 3.
//   4 SWAP a=b=2 with r2=5A -> r2 stays 5A; latency 3; no other register is written.
//   5 Load all registers nonzero; CLEAR -> wr_addr 0..7 on 8 consecutive cycles, all 0; cmd_ready=0 throughout.
//   6 Start CLEAR, assert reset at cycle 4 -> r0..r3 are 0, r4..r7 unchanged, no done, IDLE after release.

Source files
------------

// File: rtl/register_bus_sequencer.sv
// register_bus_sequencer
//   Initiator for the register file's rd0/rd1/wr buses. Takes one register-move
//   command at a time over a valid/ready handshake and runs it as a short
//   sequence of bus reads and writes: MOV, SWAP, CLEAR (every register), LOADI.
//
// Ports
//   clk, reset             clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; ready only while IDLE
//   cmd_op                 00 MOV, 01 SWAP, 10 CLEAR, 11 LOADI
//   cmd_a, cmd_b, cmd_imm  destination / source / immediate operands
//   done                   one-cycle pulse in the first IDLE cycle after the last write
//   rd0_*, rd1_*           read buses (data returns combinationally, same cycle)
//   wr_*                   write bus (register file loads at the rising edge)
module register_bus_sequencer #(
  parameter int ADDR_BITS = 3,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_BITS-1:0] cmd_a,
  input  logic [ADDR_BITS-1:0] cmd_b,
  input  logic [DATA_BITS-1:0] cmd_imm,
  output logic                 done,
  output logic [ADDR_BITS-1:0] rd0_addr,
  output logic                 rd0_en,
  input  logic [DATA_BITS-1:0] rd0_data,
  output logic [ADDR_BITS-1:0] rd1_addr,
  output logic                 rd1_en,
  input  logic [DATA_BITS-1:0] rd1_data,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic                 wr_en,
  output logic [DATA_BITS-1:0] wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_MOV, S_LDI, S_SWAP_RD, S_SWAP_WA, S_SWAP_WB, S_CLR
  } state_t;

  localparam logic [ADDR_BITS-1:0] CNT_MAX = {ADDR_BITS{1'b1}};

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   a_q, a_d, b_q, b_d, cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   imm_q, imm_d, tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
  logic                   done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      tmp_a_q <= '0;
      tmp_b_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      tmp_a_q <= tmp_a_d;
      tmp_b_q <= tmp_b_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = done_q;

  // The opcode is not stored separately: the state entered on accept encodes it.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    tmp_a_d  = tmp_a_q;
    tmp_b_d  = tmp_b_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    rd0_en   = 1'b0;
    rd0_addr = '0;
    rd1_en   = 1'b0;
    rd1_addr = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d   = cmd_a;
          b_d   = cmd_b;
          imm_d = cmd_imm;
          case (cmd_op)
            2'b00:   state_d = S_MOV;
            2'b01:   state_d = S_SWAP_RD;
            2'b10:   state_d = S_CLR;
            default: state_d = S_LDI;
          endcase
        end
      end
      S_MOV: begin
        rd0_en   = 1'b1;
        rd0_addr = b_q;
        wr_en    = 1'b1;
        wr_addr  = a_q;
        wr_data  = rd0_data;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      S_LDI: begin
        wr_en   = 1'b1;
        wr_addr = a_q;
        wr_data = imm_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_SWAP_RD: begin
        rd0_en   = 1'b1;
        rd0_addr = a_q;
        rd1_en   = 1'b1;
        rd1_addr = b_q;
        tmp_a_d  = rd0_data;
        tmp_b_d  = rd1_data;
        state_d  = S_SWAP_WA;
      end
      S_SWAP_WA: begin
        wr_en   = 1'b1;
        wr_addr = a_q;
        wr_data = tmp_b_q;
        state_d = S_SWAP_WB;
      end
      S_SWAP_WB: begin
        wr_en   = 1'b1;
        wr_addr = b_q;
        wr_data = tmp_a_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_CLR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        // Counter returns to zero on the last address so it never wraps past the top.
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_register_bus_sequencer.sv
module tb_register_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_a = '0, cmd_b = '0;
  logic [7:0] cmd_imm = '0;
  logic       done;
  logic [2:0] rd0_addr, rd1_addr, wr_addr;
  logic       rd0_en, rd1_en, wr_en;
  logic [7:0] rd0_data, rd1_data, wr_data;

  logic [7:0] rf [0:7];
  logic [7:0] snap [0:7];

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] OP_MOV = 2'b00, OP_SWAP = 2'b01, OP_CLR = 2'b10, OP_LDI = 2'b11;

  typedef struct {
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [7:0] imm;
    int         lat;
    logic [2:0] ca;
    logic [7:0] cav;
    logic [2:0] cb;
    logic [7:0] cbv;
  } vec_t;

  vec_t vt [10];

  always #5 clk = ~clk;

  // Register file behavioural model: combinational reads, write at the rising edge.
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;
  assign rd0_data = rf[rd0_addr];
  assign rd1_data = rf[rd1_addr];

  register_bus_sequencer #(.ADDR_BITS(3), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_imm(cmd_imm), .done(done),
    .rd0_addr(rd0_addr), .rd0_en(rd0_en), .rd0_data(rd0_data),
    .rd1_addr(rd1_addr), .rd1_en(rd1_en), .rd1_data(rd1_data),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command (FSM must be idle), return cycles from accept edge to done.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [7:0] imm, output int lat);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_imm = imm; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout: no done within 50 cycles");
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
  endtask

  task automatic load_all(input logic [7:0] base);
    int l;
    for (int i = 0; i < 8; i++) run_cmd(OP_LDI, 3'(i), 3'd0, base + 8'(i), l);
  endtask

  initial begin
    int lat;

    vt[0] = '{OP_LDI,  3'd1, 3'd0, 8'h11, 1, 3'd1, 8'h11, 3'd1, 8'h11};
    vt[1] = '{OP_LDI,  3'd6, 3'd0, 8'h66, 1, 3'd6, 8'h66, 3'd6, 8'h66};
    vt[2] = '{OP_SWAP, 3'd1, 3'd6, 8'h00, 3, 3'd1, 8'h66, 3'd6, 8'h11};
    vt[3] = '{OP_LDI,  3'd2, 3'd0, 8'h5A, 1, 3'd2, 8'h5A, 3'd2, 8'h5A};
    vt[4] = '{OP_MOV,  3'd7, 3'd2, 8'h00, 1, 3'd7, 8'h5A, 3'd2, 8'h5A};
    vt[5] = '{OP_LDI,  3'd4, 3'd0, 8'h3C, 1, 3'd4, 8'h3C, 3'd4, 8'h3C};
    vt[6] = '{OP_MOV,  3'd4, 3'd4, 8'h00, 1, 3'd4, 8'h3C, 3'd4, 8'h3C};
    vt[7] = '{OP_LDI,  3'd0, 3'd0, 8'hFF, 1, 3'd0, 8'hFF, 3'd0, 8'hFF};
    vt[8] = '{OP_LDI,  3'd3, 3'd0, 8'h00, 1, 3'd3, 8'h00, 3'd3, 8'h00};
    vt[9] = '{OP_SWAP, 3'd0, 3'd7, 8'h00, 3, 3'd0, 8'h5A, 3'd7, 8'hFF};

    // Reset held with a command pending: nothing may happen.
    cmd_valid = 1'b1; cmd_op = OP_LDI; cmd_a = 3'd0; cmd_imm = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_enables", {rd0_en, rd1_en, wr_en}, 3'b000);
    chk("rst_wr_addr_data", {wr_addr, wr_data}, 11'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("accept_after_rst_ready", cmd_ready, 1'b0);
    chk("accept_after_rst_wr", {wr_en, wr_addr, wr_data}, {1'b1, 3'd0, 8'h77});
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("accept_after_rst_done", done, 1'b1);
    chk("accept_after_rst_r0", rf[0], 8'h77);
    @(posedge clk); #1;

    // Back-to-back LOADI then MOV with valid held.
    cmd_valid = 1'b1; cmd_op = OP_LDI; cmd_a = 3'd3; cmd_imm = 8'hA5;
    @(posedge clk); #1;
    cmd_op = OP_MOV; cmd_a = 3'd5; cmd_b = 3'd3; cmd_imm = 8'h00;
    @(posedge clk); #1;
    chk("b2b_done1", done, 1'b1);
    chk("b2b_ready_in_done", cmd_ready, 1'b1);
    chk("b2b_r3", rf[3], 8'hA5);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_mov_done_low", done, 1'b0);
    chk("b2b_mov_bus", {rd0_en, rd0_addr, wr_en, wr_addr, wr_data},
        {1'b1, 3'd3, 1'b1, 3'd5, 8'hA5});
    @(posedge clk); #1;
    chk("b2b_done2", done, 1'b1);
    chk("b2b_r5", rf[5], 8'hA5);
    @(posedge clk); #1;

    // Table-driven commands.
    for (int i = 0; i < 10; i++) begin
      run_cmd(vt[i].op, vt[i].a, vt[i].b, vt[i].imm, lat);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_ra", i), rf[vt[i].ca], vt[i].cav);
      chk($sformatf("vec%0d_rb", i), rf[vt[i].cb], vt[i].cbv);
    end

    // SWAP a==b: full three cycles, nothing changes anywhere.
    for (int i = 0; i < 8; i++) snap[i] = rf[i];
    cmd_valid = 1'b1; cmd_op = OP_SWAP; cmd_a = 3'd2; cmd_b = 3'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("swap_rd_bus", {rd0_en, rd0_addr, rd1_en, rd1_addr, wr_en}, {1'b1, 3'd2, 1'b1, 3'd2, 1'b0});
    @(posedge clk); #1;
    chk("swap_wa_bus", {rd0_en, rd1_en, wr_en, wr_addr, wr_data}, {2'b00, 1'b1, 3'd2, 8'h5A});
    @(posedge clk); #1;
    chk("swap_wb_bus", {wr_en, wr_addr, wr_data, done}, {1'b1, 3'd2, 8'h5A, 1'b0});
    @(posedge clk); #1;
    chk("swap_same_done", done, 1'b1);
    for (int i = 0; i < 8; i++) chk($sformatf("swap_same_r%0d", i), rf[i], snap[i]);
    @(posedge clk); #1;

    // CLEAR: eight consecutive writes of zero, not ready throughout.
    load_all(8'hF0);
    cmd_valid = 1'b1; cmd_op = OP_CLR;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("clr_cyc%0d", i), {cmd_ready, done, wr_en, wr_addr, wr_data},
          {1'b0, 1'b0, 1'b1, 3'(i), 8'h00});
      @(posedge clk); #1;
    end
    chk("clr_done", done, 1'b1);
    for (int i = 0; i < 8; i++) chk($sformatf("clr_r%0d", i), rf[i], 8'h00);
    @(posedge clk); #1;
    chk("clr_done_pulse", done, 1'b0);

    // CLEAR aborted by reset after four writes.
    load_all(8'hE0);
    cmd_valid = 1'b1; cmd_op = OP_CLR;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pre_addr", wr_addr, 3'd4);
    reset = 1'b0;
    #1;
    chk("abort_bus_quiet", {wr_en, rd0_en, rd1_en, done}, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_done", done, 1'b0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("abort_r%0d", i), rf[i], (i < 4) ? 8'h00 : 8'hE0 + 8'(i));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_ready", cmd_ready, 1'b1);
    chk("abort_idle_done", done, 1'b0);
    run_cmd(OP_MOV, 3'd0, 3'd7, 8'h00, lat);
    chk("post_abort_lat", lat, 1);
    chk("post_abort_r0", rf[0], 8'hE7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
